// File: rtl/vector_loader.sv
// ----------------------------------------------------------------------------
// vector_loader
//   Collects a stream of element pairs (in_a, in_b) into two registered
//   4-lane vectors and hands the completed pair to a downstream dot-product
//   stage through a valid/ready handshake.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     clear                synchronous discard of a partially filled vector
//     in_valid / in_ready  element-pair handshake (in_a, in_b : DW bits)
//     out_valid/out_ready  completed-vector handshake
//     a0..a3, b0..b3       registered vector lanes
//     fill_cnt             lanes loaded in the current vector (0..4)
//
//   The upstream path is fully pipelined: in FULL the vector slot is freed by
//   the output transfer and refilled with lane 0 on the very same edge, so a
//   sustained stream produces one vector every 4 cycles with no bubble.
// ----------------------------------------------------------------------------

// Per-lane storage: one a/b register pair with a shared write enable.
module vector_loader_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] q_a,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] a_d, a_q;
    logic [DW-1:0] b_d, b_q;

    // Unwritten lanes keep their old contents; they are only meaningful
    // once the whole vector is marked valid.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (we) begin
            a_d = din_a;
            b_d = din_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign q_a = a_q;
    assign q_b = b_q;

endmodule

module vector_loader #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a0,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic [DW-1:0] a3,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3,
    output logic [2:0]    fill_cnt
);

    localparam int NUM_LANES = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                           state_d, state_q;
    logic [2:0]                       fill_cnt_d, fill_cnt_q;
    logic [1:0]                       wr_idx;
    logic                             in_xfer;
    logic [NUM_LANES-1:0]             lane_we;
    logic [NUM_LANES-1:0][DW-1:0]     lane_a;
    logic [NUM_LANES-1:0][DW-1:0]     lane_b;

    // Next-state, handshake and lane-select logic.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        in_xfer    = 1'b0;
        wr_idx     = 2'd0;

        case (state_q)
            FILL: begin
                // clear wins over a same-cycle input: the pair is refused,
                // not silently dropped, because in_ready goes low with it.
                in_ready = !clear;
                in_xfer  = in_valid && !clear;
                wr_idx   = fill_cnt_q[1:0];
                if (clear) begin
                    fill_cnt_d = 3'd0;
                end else if (in_valid) begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                    if (fill_cnt_q == 3'd3) begin
                        state_d = FULL;
                    end
                end
            end

            FULL: begin
                // A finished vector is never discarded, so clear is ignored.
                // Input is accepted only when the slot is being emptied on
                // the same edge; the new pair then starts the next vector.
                out_valid = 1'b1;
                in_ready  = out_ready;
                in_xfer   = in_valid && out_ready;
                wr_idx    = 2'd0;
                if (out_ready) begin
                    state_d    = FILL;
                    fill_cnt_d = in_valid ? 3'd1 : 3'd0;
                end
            end

            default: begin
                state_d    = FILL;
                fill_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Lane registers: exactly one lane is written per accepted pair.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_we[k] = in_xfer && (wr_idx == 2'(k));

        vector_loader_lane #(
            .DW(DW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (lane_we[k]),
            .din_a(in_a),
            .din_b(in_b),
            .q_a  (lane_a[k]),
            .q_b  (lane_b[k])
        );
    end

    assign a0       = lane_a[0];
    assign a1       = lane_a[1];
    assign a2       = lane_a[2];
    assign a3       = lane_a[3];
    assign b0       = lane_b[0];
    assign b1       = lane_b[1];
    assign b2       = lane_b[2];
    assign b3       = lane_b[3];
    assign fill_cnt = fill_cnt_q;

endmodule

// File: tb/tb_vector_loader.sv
// ----------------------------------------------------------------------------
// tb_vector_loader
//   Directed bench for vector_loader. Inputs change on the falling edge,
//   outputs are sampled on the falling edge (half a cycle after the rising
//   edge that updated them).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vector_loader;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] b0, b1, b2, b3;
    logic [2:0]    fill_cnt;

    int checks;
    int errors;

    vector_loader #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a0       (a0),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .b0       (b0),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .fill_cnt (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pair, let one rising edge pass, return at the falling edge.
    task automatic push(input logic [DW-1:0] va, input logic [DW-1:0] vb);
        in_valid = 1'b1;
        in_a     = va;
        in_b     = vb;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({out_valid, fill_cnt} !== 4'b0000) begin
            errors++; $display("FAIL reset_state: out_valid=%0b fill_cnt=%0d expected 0/0", out_valid, fill_cnt);
        end
        checks++;
        if ({a0, a1, a2, a3, b0, b1, b2, b3} !== 64'd0) begin
            errors++; $display("FAIL reset_lanes: a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d expected all 0", a0, a1, a2, a3, b0, b1, b2, b3);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: in_ready=%0b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int dot;
        out_ready = 1'b1;
        push(8'd1, 8'd1);
        checks++;
        if (fill_cnt !== 3'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_fill1: fill_cnt=%0d out_valid=%0b expected 1/0", fill_cnt, out_valid);
        end
        push(8'd2, 8'd2);
        push(8'd3, 8'd3);
        push(8'd4, 8'd4);
        checks++;
        if (out_valid !== 1'b1 || fill_cnt !== 3'd4) begin
            errors++; $display("FAIL basic_full: out_valid=%0b fill_cnt=%0d expected 1/4", out_valid, fill_cnt);
        end
        checks++;
        if ({a0, a1, a2, a3} !== {8'd1, 8'd2, 8'd3, 8'd4} || {b0, b1, b2, b3} !== {8'd1, 8'd2, 8'd3, 8'd4}) begin
            errors++; $display("FAIL basic_lanes: a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d expected 1,2,3,4", a0, a1, a2, a3, b0, b1, b2, b3);
        end
        dot = int'(a0) * int'(b0) + int'(a1) * int'(b1) + int'(a2) * int'(b2) + int'(a3) * int'(b3);
        checks++;
        if (dot !== 30) begin
            errors++; $display("FAIL basic_dot: got %0d expected 30", dot);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin
            errors++; $display("FAIL basic_drain: out_valid=%0b fill_cnt=%0d expected 0/0", out_valid, fill_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(8'd11, 8'd21);
        push(8'd12, 8'd22);
        push(8'd13, 8'd23);
        push(8'd14, 8'd24);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || a0 !== 8'd11 || b3 !== 8'd24) begin
                errors++; $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b a0=%0d b3=%0d expected 0/1/11/24", i, in_ready, out_valid, a0, b3);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_follow: in_ready=%0b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd1 || a0 !== 8'd9 || b0 !== 8'd9 || a1 !== 8'd12) begin
            errors++; $display("FAIL bp_release: out_valid=%0b fill_cnt=%0d a0=%0d b0=%0d a1=%0d expected 0/1/9/9/12", out_valid, fill_cnt, a0, b0, a1);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (fill_cnt !== 3'd0) begin
            errors++; $display("FAIL bp_clear: fill_cnt=%0d expected 0", fill_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int vectors;
        vectors   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'd1;
        in_b      = 8'd101;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) vectors++;
            checks++;
            if (out_valid !== ((i % 4) == 3)) begin
                errors++; $display("FAIL b2b_valid[%0d]: out_valid=%0b expected %0b", i, out_valid, (i % 4) == 3);
            end
            if ((i % 4) == 3) begin
                checks++;
                if (a0 !== 8'(i - 2) || a3 !== 8'(i + 1) || b0 !== 8'(i + 98)) begin
                    errors++; $display("FAIL b2b_data[%0d]: a0=%0d a3=%0d b0=%0d expected %0d/%0d/%0d", i, a0, a3, b0, i - 2, i + 1, i + 98);
                end
            end
            in_a = 8'(i + 2);
            in_b = 8'(i + 102);
        end
        in_valid = 1'b0;
        checks++;
        if (vectors !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d vectors expected 4", vectors);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin
            errors++; $display("FAIL b2b_drain: out_valid=%0b fill_cnt=%0d expected 0/0", out_valid, fill_cnt);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        push(8'd50, 8'd60);
        push(8'd51, 8'd61);
        clear = 1'b1; in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL clear_in_ready: in_ready=%0b expected 0", in_ready);
        end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (fill_cnt !== 3'd0) begin
            errors++; $display("FAIL clear_cnt: fill_cnt=%0d expected 0", fill_cnt);
        end
        push(8'd5, 8'd6);
        push(8'd7, 8'd8);
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        checks++;
        if (out_valid !== 1'b1 || {a0, a1, a2, a3} !== {8'd5, 8'd7, 8'd1, 8'd3} || {b0, b1, b2, b3} !== {8'd6, 8'd8, 8'd2, 8'd4}) begin
            errors++; $display("FAIL clear_vector: out_valid=%0b a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d expected 1 a=5,7,1,3 b=6,8,2,4", out_valid, a0, a1, a2, a3, b0, b1, b2, b3);
        end
    endtask

    // Continues from the FULL vector left by test_clear.
    task automatic test_clear_full();
        clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || fill_cnt !== 3'd4 || {a0, a1, a2, a3} !== {8'd5, 8'd7, 8'd1, 8'd3} || b3 !== 8'd4) begin
            errors++; $display("FAIL clear_full_hold: out_valid=%0b fill_cnt=%0d a=%0d,%0d,%0d,%0d b3=%0d expected 1/4 5,7,1,3 4", out_valid, fill_cnt, a0, a1, a2, a3, b3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd0) begin
            errors++; $display("FAIL clear_full_drain: out_valid=%0b fill_cnt=%0d expected 0/0", out_valid, fill_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        push(8'd40, 8'd41);
        push(8'd42, 8'd43);
        push(8'd44, 8'd45);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd0 || a0 !== 8'd0 || b2 !== 8'd0) begin
            errors++; $display("FAIL arst_immediate: out_valid=%0b fill_cnt=%0d a0=%0d b2=%0d expected 0/0/0/0", out_valid, fill_cnt, a0, b2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_in_ready: in_ready=%0b expected 1", in_ready);
        end
        push(8'd21, 8'd31);
        push(8'd22, 8'd32);
        push(8'd23, 8'd33);
        push(8'd24, 8'd34);
        checks++;
        if (out_valid !== 1'b1 || {a0, a1, a2, a3} !== {8'd21, 8'd22, 8'd23, 8'd24} || {b0, b1, b2, b3} !== {8'd31, 8'd32, 8'd33, 8'd34}) begin
            errors++; $display("FAIL arst_vector: out_valid=%0b a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d expected 1 a=21..24 b=31..34", out_valid, a0, a1, a2, a3, b0, b1, b2, b3);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_clear_full();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net: the directed sequence is a few hundred cycles at most.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter DW, default 8, element width of every vector lane.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 clear  input  1  synchronous discard of a partially filled vector.
REQ-005 in_valid  input  1  upstream offers one element pair.
REQ-006 in_ready  output  1  loader accepts the offered pair this cycle.
REQ-007 in_a  input  DW  element of vector a.
REQ-008 in_b  input  DW  element of vector b.
REQ-009 out_valid  output  1  complete 4-lane vector pair is presented.
REQ-010 out_ready  input  1  downstream dot-product stage consumes the vector.
REQ-011 a0, a1, a2, a3  output  DW each  vector a lanes, registered.
REQ-012 b0, b1, b2, b3  output  DW each  vector b lanes, registered.
REQ-013 fill_cnt  output  3  number of lanes loaded in the current vector (0-4).

Function
REQ-014 An input transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-015 An output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Transfer k (k=0..3) of a vector writes in_a to ak and in_b to bk; lane order is fixed, first-in goes to lane 0.
REQ-017 The FSM has two states: FILL (out_valid=0) and FULL (out_valid=1).
REQ-018 In FILL: in_ready=1; each transfer increments fill_cnt; the transfer that makes fill_cnt 4 moves the FSM to FULL on the same edge.
REQ-019 Latency: out_valid rises on the edge that accepts the 4th pair, so it is visible in the following cycle.
REQ-020 In FULL: a0..a3 and b0..b3 hold stable until the output transfer, regardless of in_* activity.
REQ-021 In FULL: in_ready=out_ready (combinational); a simultaneous input and output transfer writes the new pair to lane 0, sets fill_cnt=1, and enters FILL.
REQ-022 In FULL, an output transfer without an input transfer sets fill_cnt=0 and enters FILL.
REQ-023 Sustained in_valid=1 and out_ready=1 therefore yields one vector every 4 cycles with no bubble.
REQ-024 Lanes not yet written in the current vector keep their previous values; downstream uses them only when out_valid=1.
REQ-025 clear=1 in FILL sets fill_cnt=0 and drops any same-cycle input transfer (in_ready=0 while clear=1).
REQ-026 clear=1 in FULL has no effect; a completed vector is never discarded.
REQ-027 in_ready depends on out_ready and clear only; it never depends on in_valid.
REQ-028 Element values pass unmodified; no arithmetic, no width change.

Reset
REQ-029 rst_n=0 immediately forces FILL, fill_cnt=0, out_valid=0, a0..a3=0, and b0..b3=0, independent of clk.
REQ-030 Reset mid-vector or in FULL discards all loaded data; the first transfer after release goes to lane 0.
REQ-031 in_ready=1 during the first cycle after rst_n deasserts, provided clear=0.

Verification
REQ-032 Stream pairs (1,1),(2,2),(3,3),(4,4) with out_ready=1 -> out_valid=1 for one cycle with a=b=[1,2,3,4]; downstream dot_product result=30.
REQ-033 Fill 4 pairs with out_ready=0 for 5 cycles and keep offering (9,9) -> in_ready=0, lanes held at the first vector; on out_ready=1, (9,9) lands in a0/b0 and fill_cnt=1.
REQ-034 Continuous in_valid=1 and out_ready=1 for 16 cycles -> exactly 4 output vectors, out_valid asserted every 4th cycle.
REQ-035 Load 2 pairs, pulse clear, then load (5,6),(7,8),(1,2),(3,4) -> output a=[5,7,1,3], b=[6,8,2,4].
REQ-036 Load 3 pairs, assert rst_n=0 between edges -> out_valid=0 and fill_cnt=0 immediately; the next 4 pairs form a clean vector.
REQ-037 Apply clear=1 while FULL with out_ready=0 -> vector retained; out_valid stays 1 with unchanged lanes.
